// File: rtl/dbus_dual_issue_if.sv
// Data-bus request/response types and the bundle linking the memory stages,
// the serialiser and the single-ported data bus.
package dbus_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

interface dbus_dual_issue_if;
    import dbus_pkg::*;

    dbus_req_t  [1:0] dreq;
    dbus_resp_t [1:0] dresp;
    logic             d_wait;
    dbus_req_t        bus_req;
    dbus_resp_t       bus_resp;

    modport slave (
        input  dreq,
        input  bus_resp,
        output bus_req,
        output dresp,
        output d_wait
    );

    modport master (
        output dreq,
        output bus_resp,
        input  bus_req,
        input  dresp,
        input  d_wait
    );

endinterface

// File: rtl/dbus_dual_issue.sv
// Serialises the two per-slot data requests of the dual-issue pipeline onto
// one data bus, older slot 1 first, stalling the pipeline until the pair is done.
module dbus_dual_issue
    import dbus_pkg::*;
(
    input logic              clk,
    input logic              reset,
    dbus_dual_issue_if.slave io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   cur_q, cur_d;

    logic   any_valid;
    logic   s;
    logic   issue;
    logic   accepted;
    logic   complete;
    logic   last;

    dbus_req_t        bus_req_o;
    dbus_resp_t [1:0] dresp_o;
    logic             d_wait_o;

    // In IDLE the active slot is picked straight from the incoming pair so a
    // bus hit can complete without any registered delay.
    always_comb begin
        any_valid = io.dreq[1].valid | io.dreq[0].valid;
        s         = (state_q == IDLE) ? io.dreq[1].valid : cur_q;
        issue     = ((state_q == IDLE) & any_valid) | (state_q == ADDR);
        accepted  = issue & io.bus_resp.addr_ok;
        complete  = io.bus_resp.data_ok & ((state_q == DATA) | accepted);
        last      = complete & (~s | ~io.dreq[0].valid);
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            IDLE, ADDR: begin
                if (issue) begin
                    if (accepted) begin
                        if (last) begin
                            state_d = IDLE;
                            cur_d   = 1'b0;
                        end else if (complete) begin
                            state_d = ADDR;
                            cur_d   = 1'b0;
                        end else begin
                            state_d = DATA;
                            cur_d   = s;
                        end
                    end else begin
                        state_d = ADDR;
                        cur_d   = s;
                    end
                end
            end
            DATA: begin
                if (io.bus_resp.data_ok) begin
                    state_d = last ? IDLE : ADDR;
                    cur_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cur_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    // Outputs are purely combinational; forcing them low during reset keeps a
    // held request from leaking onto the bus before the first clock edge.
    always_comb begin
        bus_req_o       = io.dreq[s];
        bus_req_o.valid = issue;

        dresp_o[0].addr_ok = accepted & ~s;
        dresp_o[0].data_ok = complete & ~s;
        dresp_o[0].data    = io.bus_resp.data;
        dresp_o[1].addr_ok = accepted & s;
        dresp_o[1].data_ok = complete & s;
        dresp_o[1].data    = io.bus_resp.data;

        d_wait_o = ((state_q != IDLE) | any_valid) & ~last;

        if (reset) begin
            bus_req_o = '0;
            dresp_o   = '0;
            d_wait_o  = 1'b0;
        end
    end

    assign io.bus_req = bus_req_o;
    assign io.dresp   = dresp_o;
    assign io.d_wait  = d_wait_o;

    a_no_issue_in_data : assert property (
        @(posedge clk) disable iff (reset) (state_q == DATA) |-> !bus_req_o.valid
    );

    a_release_means_idle : assert property (
        @(posedge clk) disable iff (reset) !d_wait_o |-> (state_d == IDLE)
    );

endmodule

// File: doc/dbus_dual_issue.md
# dbus_dual_issue

Serialises the two per-slot data-memory requests of the dual-issue pipeline onto the single-ported data bus. It sits between the memory-1 stage, which builds `dreq[1:0]`, and the data bus / memory-2 stage, which consumes `dresp[1:0]`. It returns a per-slot response and drives the pipeline stall `d_wait` until every valid request of the current pair has completed. Slot 1 is the older instruction and is always serviced first.

## Interface
- Parameters: none.
- `clk` in 1: pipeline clock.
- `reset` in 1: asynchronous, active-high reset.
- `dreq` in `dbus_req_t [1:0]`: per-slot requests; fields `valid`, `addr`, `size`, `strobe`, `data`. Held stable by the pipeline while `d_wait=1`.
- `bus_req` out `dbus_req_t`: request to the data bus.
- `bus_resp` in `dbus_resp_t`: bus response; fields `addr_ok`, `data_ok`, `data`.
- `dresp` out `dbus_resp_t [1:0]`: per-slot response to memory-2.
- `d_wait` out 1: stall for the whole pipeline.

## Operation
- Registers:
  - `state` ∈ {IDLE, ADDR, DATA}.
  - `cur`: slot being serviced.
- Active slot `s`: `cur` when state≠IDLE; in IDLE, `s = dreq[1].valid ? 1 : 0`.
- `bus_req`:
  - Fields are copied combinationally from `dreq[s]`.
  - `bus_req.valid` = (IDLE & (`dreq[1].valid` | `dreq[0].valid`)) | (state==ADDR).
  - `bus_req.valid` is 0 in DATA.
- A request is accepted in a cycle with `bus_req.valid & addr_ok`.
- A request completes in a cycle with `data_ok` while in DATA, or in the same cycle as its acceptance.
- `complete` = slot `s` completes this cycle.
- `last` = `complete` & (s==0 | ~`dreq[0].valid`).
- Transitions from IDLE (with a valid request) or from ADDR:
  - Accepted & complete & ~last → ADDR, `cur`=0.
  - Accepted & last → IDLE.
  - Accepted & ~complete → DATA, `cur`=s.
  - Not accepted → ADDR, `cur`=s.
- Transitions from DATA:
  - `data_ok` & ~last → ADDR, `cur`=0.
  - `data_ok` & last → IDLE.
  - Otherwise stay in DATA.
- IDLE with no valid request: stay in IDLE; `bus_req.valid`=0.
- `dresp[i].data_ok` = `complete` & (s==i), a one-cycle pulse.
- `dresp[i].data` = `bus_resp.data` for both slots.
- `dresp[i].addr_ok` = accepted & (s==i).
- `d_wait` = ((IDLE & any `dreq` valid) | state≠IDLE) & ~`last`.
  - It falls in the same cycle the final `data_ok` arrives, so the pipeline advances on that edge.
- Slot-1 data is presented only in its own completion cycle. Memory-2 holds it across the slot-0 wait.
- `data_ok` while no transaction is active (IDLE, no valid `dreq`) is ignored.
- Reset mid-transaction:
  - `state`→IDLE and `cur`→0 immediately.
  - All outputs read 0 while `reset=1`.
  - The bus shares `reset`, so no stale response is expected.

## Timing
- Reset values: `bus_req`=0, `dresp`=0, `d_wait`=0, `state`=IDLE, `cur`=0.
- Single request, `addr_ok` and `data_ok` in the same cycle: zero added cycles. `d_wait` stays 0 and `dresp[s].data_ok` pulses in the issue cycle.
- Pair, each request hit in the same cycle: 2 cycles.
  - Cycle 0: slot 1 completes, `d_wait`=1.
  - Cycle 1: slot 0 completes, `d_wait`=0.
- Each extra cycle without `addr_ok` or `data_ok` adds one cycle.
- At most one outstanding bus transaction at any time.
- Slot 0 is never issued before slot 1 has completed.
- Every output is combinational from `state`, `cur`, `dreq` and `bus_resp`. There is no registered output, so there is no bubble after completion.

## Test plan
- Only `dreq[0].valid`, addr 0x8000_0010, `addr_ok=data_ok=1` in cycle 0 → `bus_req.addr`=0x8000_0010, `dresp[0].data_ok`=1 in cycle 0, `d_wait`=0 throughout, state remains IDLE.
- Both slots valid (addr 0x100 / 0x200), bus hits every cycle:
  - Cycle 0: `bus_req.addr`=0x100, `dresp[1].data_ok`=1, `d_wait`=1.
  - Cycle 1: `bus_req.addr`=0x200, `dresp[0].data_ok`=1, `d_wait`=0.
- Slot 1 only; `addr_ok` in cycle 1; `data_ok` in cycle 4 with data 0xDEAD_BEEF:
  - ADDR in cycle 1, DATA in cycles 2–4.
  - `bus_req.valid`=0 in cycles 2–4.
  - `dresp[1]` = {data_ok=1, data=0xDEAD_BEEF} in cycle 4; `d_wait` falls in cycle 4.
- Both valid; slot 1 takes 3 cycles to `data_ok`, slot 0 hits → `dresp[1].data_ok` in cycle 2, `dresp[0].data_ok` in cycle 3, `d_wait`=1 in cycles 0–2 and 0 in cycle 3.
- `reset` asserted asynchronously while in DATA → `state`=IDLE and `bus_req.valid`=`d_wait`=0 immediately, without waiting for a clock edge. After release with no `dreq`, outputs stay 0.
- Spurious `bus_resp.data_ok`=1 in IDLE with no valid `dreq` → `dresp[1:0].data_ok`=0, `d_wait`=0, state stays IDLE.
